ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter. It sends one command byte to the keyboard, e.g. 0xED (set LEDs) followed by the LED mask, or 0xFF (reset).
- It is the opposite direction to the existing keyboard receiver and shares the same ps2clk/ps2data lines through open-drain enables at the top level.
- It runs on the pixel clock (clkdiv4, 25 MHz) and exposes a valid/ready byte interface plus done/error pulses.

---
 rtl/ps2_pkg.sv | 32 +++
 rtl/ps2_line_sync.sv | 74 +++++++
 rtl/ps2_host_tx.sv | 160 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
`timescale 1ns/1ps
// Shared PS/2 definitions: FSM encodings, frame geometry, clock-derived timing defaults, parity helper.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package ps2_pkg;

    localparam int CLK_FREQ_HZ_DEF    = 25_000_000;
    // 100 us request-to-send hold and 15 ms device-silence limit.
    localparam int INHIBIT_CYCLES_DEF = CLK_FREQ_HZ_DEF / 10_000;
    localparam int TIMEOUT_CYCLES_DEF = (CLK_FREQ_HZ_DEF / 1_000) * 15;

    localparam int FRAME_BITS = 10;
    // Index of the last host-driven bit (stop); its fall hands the line to the device for ACK.
    localparam int ACK_IDX    = FRAME_BITS - 1;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INHIBIT   = 3'd1;
    localparam logic [2:0] ST_REQ       = 3'd2;
    localparam logic [2:0] ST_SEND      = 3'd3;
    localparam logic [2:0] ST_ACK       = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;
    localparam logic [2:0] ST_ERR       = 3'd6;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] d);
        return {1'b1, odd_parity(d), d};
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
`timescale 1ns/1ps
// PS/2 pin conditioning: 2-flop synchronisers, optional clock glitch filter (PS2_TX_GLITCH_FILTER_EN), fall strobe.
// Latency: fall strobe 3 clk after the pin edge, 11 clk when the glitch filter is built in.
// Backpressure: none; free-running, one single-cycle strobe per accepted falling edge.
module ps2_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2clk_in,
    input  logic ps2data_in,
    output logic sync_clk,
    output logic sync_data,
    output logic fall
);

    logic [1:0] clk_meta_q, clk_meta_d;
    logic [1:0] data_meta_q, data_meta_d;
    logic       clk_prev_q, clk_prev_d;
    logic       clk_lvl;

    always_comb begin
        clk_meta_d  = {clk_meta_q[0], ps2clk_in};
        data_meta_d = {data_meta_q[0], ps2data_in};
        clk_prev_d  = clk_lvl;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_meta_q  <= 2'b11;
            data_meta_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_meta_q  <= clk_meta_d;
            data_meta_q <= data_meta_d;
            clk_prev_q  <= clk_prev_d;
        end
    end

`ifdef PS2_TX_GLITCH_FILTER_EN
    logic       filt_q, filt_d;
    logic [2:0] filt_cnt_q, filt_cnt_d;

    // Level follows the pin only after 8 consecutive disagreeing samples; any agreeing sample restarts the count.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = 3'd0;
        if (clk_meta_q[1] != filt_q) begin
            if (filt_cnt_q == 3'd7) begin
                filt_d = clk_meta_q[1];
            end else begin
                filt_cnt_d = filt_cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= 3'd0;
        end else begin
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

    assign clk_lvl = filt_q;
`else
    assign clk_lvl = clk_meta_q[1];
`endif

    assign sync_clk  = clk_lvl;
    assign sync_data = data_meta_q[1];
    assign fall      = clk_prev_q & ~clk_lvl;

endmodule

// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
// PS/2 host-to-device byte transmitter (inhibit, request-to-send, 10 bits on device falls, ACK check); PS2_TX_GLITCH_FILTER_EN filters ps2clk.
// Latency: INHIBIT_CYCLES + 1 clk before the device clocks, then one bit per device fall; done/err pulse at frame end.
// Backpressure: tx_ready high only when idle; tx_valid while busy is dropped, nothing is queued.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ_HZ    = CLK_FREQ_HZ_DEF,
    parameter int INHIBIT_CYCLES = CLK_FREQ_HZ / 10_000,
    parameter int TIMEOUT_CYCLES = (CLK_FREQ_HZ / 1_000) * 15,
    parameter int CNT_W          = 19
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       busy,
    input  logic       ps2clk_in,
    input  logic       ps2data_in,
    output logic       ps2clk_oe,
    output logic       ps2data_oe
);

    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [3:0]       LAST_BIT = 4'(ACK_IDX);

    logic                  sync_clk, sync_data, fall;

    logic [2:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      cnt_inc;
    logic [3:0]            bit_idx_q, bit_idx_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic                  data_oe_q, data_oe_d;
    logic                  done_q, done_d;
    logic                  timed_out;

    ps2_line_sync u_line_sync (
        .clk        (clk),
        .rst_n      (reset),
        .ps2clk_in  (ps2clk_in),
        .ps2data_in (ps2data_in),
        .sync_clk   (sync_clk),
        .sync_data  (sync_data),
        .fall       (fall)
    );

    // Saturating so a stuck counter can never wrap around and look like fresh activity.
    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    assign timed_out = (cnt_q == TO_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        frame_d   = frame_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tx_valid) begin
                    frame_d   = build_frame(tx_data);
                    cnt_d     = '0;
                    data_oe_d = 1'b0;
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_REQ;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_REQ: begin
                bit_idx_d = 4'd0;
                cnt_d     = '0;
                data_oe_d = 1'b1;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                // A fall on the timeout cycle still counts as a valid edge.
                if (fall) begin
                    data_oe_d = ~frame_q[bit_idx_q];
                    bit_idx_d = bit_idx_q + 4'd1;
                    cnt_d     = '0;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = ST_ACK;
                    end
                end else if (timed_out) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_ACK: begin
                if (fall) begin
                    cnt_d   = '0;
                    state_d = sync_data ? ST_ERR : ST_WAIT_IDLE;
                end else if (timed_out) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_WAIT_IDLE: begin
                if (sync_clk && sync_data) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (fall) begin
                    cnt_d = '0;
                end else if (timed_out) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 4'd0;
            frame_q   <= '0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            frame_q   <= frame_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
        end
    end

    // Line enables decode straight from state so an asynchronous reset releases the bus at once.
    assign tx_ready   = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign ps2clk_oe  = (state_q == ST_INHIBIT) || (state_q == ST_REQ);
    assign ps2data_oe = (state_q == ST_REQ) || ((state_q == ST_SEND) && data_oe_q);
    assign tx_done    = done_q;
    assign tx_err     = (state_q == ST_ERR);

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
// Bench for ps2_host_tx: table of bytes sent to a PS/2 device model, plus timeout and mid-frame reset sequences.
module tb_ps2_host_tx;

    localparam int INH  = 50;
    localparam int TO   = 300;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, tx_done, tx_err, busy;
    logic       ps2clk_oe, ps2data_oe;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2clk_in, ps2data_in;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int err_seen = 0;

    always #20 clk = ~clk;

    assign ps2clk_in  = dev_clk & ~ps2clk_oe;
    assign ps2data_in = dev_data & ~ps2data_oe;

    ps2_host_tx #(
        .CLK_FREQ_HZ   (25_000_000),
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO),
        .CNT_W         (9)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .busy       (busy),
        .ps2clk_in  (ps2clk_in),
        .ps2data_in (ps2data_in),
        .ps2clk_oe  (ps2clk_oe),
        .ps2data_oe (ps2data_oe)
    );

    always @(negedge clk) begin
        if (tx_done === 1'b1) done_seen++;
        if (tx_err === 1'b1) err_seen++;
    end

    typedef struct {
        logic [7:0] data;
        bit         ack;
        logic [9:0] exp_bits;
        int         exp_done;
        int         exp_err;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Hands a byte over, then measures how long the inhibit and request phases last.
    task automatic send_byte(input logic [7:0] d, output int inh_n, output int req_n);
        int n;
        n = 0;
        while (!tx_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_valid = 1'b0;
        inh_n = 0;
        while (ps2clk_oe && !ps2data_oe && inh_n < INH + 100) begin
            inh_n++;
            @(negedge clk);
        end
        req_n = 0;
        while (ps2clk_oe && ps2data_oe && req_n < 100) begin
            req_n++;
            @(negedge clk);
        end
    endtask

    // Device model: 11 clock pulses, reads host bits late in each low phase, optionally drives ACK.
    task automatic dev_frame(input bit ack, input bit glitch, output logic start_bit, output logic [9:0] bits);
        bits = '0;
        repeat (HALF) @(negedge clk);
        start_bit = ps2data_in;
        for (int k = 0; k < 11; k++) begin
            dev_clk = 1'b0;
            if (k == 10 && ack) dev_data = 1'b0;
            repeat (HALF) @(negedge clk);
            if (k < 10) bits[k] = ps2data_in;
            dev_clk = 1'b1;
            if (glitch) begin
                repeat (6) @(negedge clk);
                dev_clk = 1'b0;
                repeat (5) @(negedge clk);
                dev_clk = 1'b1;
                repeat (HALF - 11) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            dev_data = 1'b1;
        end
    endtask

    task automatic run_vec(input vec_t v, input bit glitch, input string tag);
        int         inh_n, req_n, d0, e0, n;
        logic       sb;
        logic [9:0] bits;
        d0 = done_seen;
        e0 = err_seen;
        send_byte(v.data, inh_n, req_n);
        check({tag, " inhibit_len"}, inh_n, INH);
        check({tag, " req_len"}, req_n, 1);
        check({tag, " busy"}, busy, 1'b1);
        dev_frame(v.ack, glitch, sb, bits);
        check({tag, " start_bit"}, sb, 1'b0);
        check({tag, " frame_bits"}, bits, v.exp_bits);
        n = 0;
        while (!tx_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        check({tag, " ready_after"}, tx_ready, 1'b1);
        check({tag, " done_pulses"}, done_seen - d0, v.exp_done);
        check({tag, " err_pulses"}, err_seen - e0, v.exp_err);
        check({tag, " lines_released"}, {ps2clk_oe, ps2data_oe}, 2'b00);
    endtask

    initial begin
        int   n, inh_n, req_n, d0, e0;
        vec_t gv;

        vecs[0] = '{8'hED, 1'b1, 10'h3ED, 1, 0};
        vecs[1] = '{8'h07, 1'b1, 10'h207, 1, 0};
        vecs[2] = '{8'h00, 1'b0, 10'h300, 0, 1};
        vecs[3] = '{8'hFF, 1'b1, 10'h3FF, 1, 0};

        repeat (3) @(negedge clk);
        check("rst tx_ready", tx_ready, 1'b1);
        check("rst busy", busy, 1'b0);
        check("rst ps2clk_oe", ps2clk_oe, 1'b0);
        check("rst ps2data_oe", ps2data_oe, 1'b0);
        check("rst tx_done", tx_done, 1'b0);
        check("rst tx_err", tx_err, 1'b0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));
        end

        // Device never clocks: error exactly TO cycles into SEND, late tx_valid ignored.
        d0 = done_seen;
        e0 = err_seen;
        send_byte(8'hFF, inh_n, req_n);
        check("to inhibit_len", inh_n, INH);
        tx_data = 8'h55;
        n = 0;
        while (!tx_err && n < TO + 50) begin
            @(negedge clk);
            n++;
            tx_valid = (n == 5);
        end
        tx_valid = 1'b0;
        check("to err_delay", n, TO);
        check("to oe_at_err", {ps2clk_oe, ps2data_oe}, 2'b00);
        repeat (20) @(negedge clk);
        check("to ready_after", tx_ready, 1'b1);
        check("to no_queued_req", ps2clk_oe, 1'b0);
        check("to err_pulses", err_seen - e0, 1);
        check("to done_pulses", done_seen - d0, 0);

        // Reset during the low phase after the 4th device fall.
        d0 = done_seen;
        e0 = err_seen;
        send_byte(8'hA5, inh_n, req_n);
        repeat (HALF) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            if (k < 3) begin
                dev_clk = 1'b1;
                repeat (HALF) @(negedge clk);
            end
        end
        check("rstmid busy_before", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("rstmid ps2clk_oe", ps2clk_oe, 1'b0);
        check("rstmid ps2data_oe", ps2data_oe, 1'b0);
        check("rstmid tx_ready", tx_ready, 1'b1);
        @(negedge clk);
        dev_clk = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (100) @(negedge clk);
        check("rstmid ready_after", tx_ready, 1'b1);
        check("rstmid idle_lines", {ps2clk_oe, ps2data_oe}, 2'b00);
        check("rstmid done_pulses", done_seen - d0, 0);
        check("rstmid err_pulses", err_seen - e0, 0);

`ifdef PS2_TX_GLITCH_FILTER_EN
        gv = '{8'hED, 1'b1, 10'h3ED, 1, 0};
        run_vec(gv, 1'b1, "glitch");
`else
        gv = vecs[1];
        run_vec(gv, 1'b0, "repeat07");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
